// File: rtl/data_mem_responder.sv
// Data-memory responder for the M stage: word-addressed RAM plus an MMIO block
// with an LED register, a free-running cycle counter and a compare/irq unit.
module data_mem_responder #(
    parameter int          RAM_AW  = 6,
    parameter logic [15:0] MMIO_HI = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwriteM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic [15:0] leds,
    output logic        irq,
    output logic        addr_err
);

    localparam logic [15:0] OFF_LED    = 16'h0000;
    localparam logic [15:0] OFF_CYCLE  = 16'h0004;
    localparam logic [15:0] OFF_CMP    = 16'h0008;
    localparam logic [15:0] OFF_STATUS = 16'h000C;
    localparam int          RAM_WORDS  = 1 << RAM_AW;

    logic [31:0]       ram_r [0:RAM_WORDS-1];
    logic [15:0]       led_r;
    logic [31:0]       cycle_r;
    logic [31:0]       cmp_r;
    logic [2:0]        status_r;

    logic              mmio_sel_s;
    logic              aligned_s;
    logic              misaligned_s;
    logic              ram_we_s;
    logic              led_we_s;
    logic              cyc_we_s;
    logic              cmp_we_s;
    logic              sts_we_s;
    logic              match_s;
    logic [RAM_AW-1:0] idx_s;
    logic [15:0]       off_s;
    logic [2:0]        sts_nxt_s;

    assign mmio_sel_s   = (aluoutM[31:16] == MMIO_HI);
    assign aligned_s    = (aluoutM[1:0] == 2'b00);
    assign misaligned_s = memwriteM & ~aligned_s;
    assign idx_s        = aluoutM[RAM_AW+1:2];
    assign off_s        = aluoutM[15:0];
    // Compare uses the pre-increment count and the CMP value held before this edge.
    assign match_s      = (cmp_r != 32'd0) && (cycle_r == cmp_r);

    // Address decode into per-target write strobes; misaligned stores go nowhere.
    always_comb begin
        ram_we_s = 1'b0;
        led_we_s = 1'b0;
        cyc_we_s = 1'b0;
        cmp_we_s = 1'b0;
        sts_we_s = 1'b0;
        if (memwriteM && aligned_s) begin
            if (mmio_sel_s) begin
                case (off_s)
                    OFF_LED:    led_we_s = 1'b1;
                    OFF_CYCLE:  cyc_we_s = 1'b1;
                    OFF_CMP:    cmp_we_s = 1'b1;
                    OFF_STATUS: sts_we_s = 1'b1;
                    default:    led_we_s = 1'b0;
                endcase
            end else begin
                ram_we_s = 1'b1;
            end
        end else begin
            ram_we_s = 1'b0;
        end
    end

    // STATUS next value: hardware set beats a same-edge write-one-to-clear.
    always_comb begin
        sts_nxt_s[0] = match_s      | (status_r[0] & ~(sts_we_s & writedataM[0]));
        sts_nxt_s[1] = misaligned_s | (status_r[1] & ~(sts_we_s & writedataM[1]));
        if (sts_we_s) begin
            sts_nxt_s[2] = writedataM[2];
        end else begin
            sts_nxt_s[2] = status_r[2];
        end
    end

    // Zero-latency load mux; a same-cycle store is not visible until the next cycle.
    always_comb begin
        readdataM = 32'd0;
        if (mmio_sel_s) begin
            case (off_s)
                OFF_LED:    readdataM = {16'd0, led_r};
                OFF_CYCLE:  readdataM = cycle_r;
                OFF_CMP:    readdataM = cmp_r;
                OFF_STATUS: readdataM = {29'd0, status_r};
                default:    readdataM = 32'd0;
            endcase
        end else begin
            readdataM = ram_r[idx_s];
        end
    end

    // RAM array has no reset, so stores land even while rst is asserted.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[idx_s] <= writedataM;
        end
    end

    // MMIO registers; a CYCLE write takes priority over that edge's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_r    <= 16'd0;
            cycle_r  <= 32'd0;
            cmp_r    <= 32'd0;
            status_r <= 3'd0;
        end else begin
            if (led_we_s) begin
                led_r <= writedataM[15:0];
            end
            if (cyc_we_s) begin
                cycle_r <= 32'd0;
            end else begin
                cycle_r <= cycle_r + 32'd1;
            end
            if (cmp_we_s) begin
                cmp_r <= writedataM;
            end
            status_r <= sts_nxt_s;
        end
    end

    assign leds     = led_r;
    assign irq      = status_r[0] & status_r[2];
    assign addr_err = status_r[1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM aliasing, read-before-write,
// misaligned stores, compare/irq, cycle counter clear and wrap, LED register.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;
    logic [15:0] leds;
    logic        irq;
    logic        addr_err;

    int total_cnt;
    int bad_cnt;

    data_mem_responder #(.RAM_AW(6), .MMIO_HI(16'hFFFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .memwriteM  (memwriteM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .leds       (leds),
        .irq        (irq),
        .addr_err   (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given bus values; returns 1 time unit after the edge.
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
        memwriteM  = we;
        aluoutM    = a;
        writedataM = d;
        @(posedge clk);
        #1;
        memwriteM  = 1'b0;
        aluoutM    = 32'd0;
        writedataM = 32'd0;
    endtask

    task automatic peek(input logic [31:0] a);
        memwriteM = 1'b0;
        aluoutM   = a;
        #1;
    endtask

    initial begin
        total_cnt  = 0;
        bad_cnt    = 0;
        rst        = 1'b1;
        memwriteM  = 1'b0;
        aluoutM    = 32'd0;
        writedataM = 32'd0;
        step(1'b0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        check("rst_leds", {16'd0, leds}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        peek(32'hFFFF000C);
        check("rst_status", readdataM, 32'd0);

        // RAM store, readback and alias at +256 bytes
        step(1'b1, 32'h0000_0010, 32'hDEADBEEF);
        peek(32'h0000_0010);
        check("ram_read", readdataM, 32'hDEADBEEF);
        peek(32'h0000_0110);
        check("ram_alias", readdataM, 32'hDEADBEEF);
        peek(32'h1234_0010);
        check("ram_alias_hi", readdataM, 32'hDEADBEEF);

        // Read returns old data in the store cycle
        step(1'b1, 32'h0000_0020, 32'h0000_0005);
        memwriteM  = 1'b1;
        aluoutM    = 32'h0000_0020;
        writedataM = 32'h0000_0001;
        #1;
        check("rbw_old", readdataM, 32'h0000_0005);
        @(posedge clk);
        #1;
        memwriteM = 1'b0;
        peek(32'h0000_0020);
        check("rbw_new", readdataM, 32'h0000_0001);

        // Misaligned store is suppressed and flagged; W1C clears the flag
        step(1'b1, 32'h0000_0013, 32'h0000_0077);
        peek(32'h0000_0010);
        check("misal_ram", readdataM, 32'hDEADBEEF);
        check("misal_flag", {31'd0, addr_err}, 32'd1);
        peek(32'hFFFF000C);
        check("misal_status", readdataM, 32'h0000_0002);
        step(1'b1, 32'hFFFF_000C, 32'h0000_0002);
        check("misal_w1c", {31'd0, addr_err}, 32'd0);

        // Compare/irq: after reset edge E0 CYCLE=0, then +1 per edge
        rst = 1'b1;
        step(1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        step(1'b1, 32'hFFFF_0008, 32'd10);
        step(1'b1, 32'hFFFF_000C, 32'h0000_0004);
        for (int k = 3; k <= 10; k++) begin
            step(1'b0, 32'd0, 32'd0);
        end
        check("irq_before", {31'd0, irq}, 32'd0);
        peek(32'hFFFF0004);
        check("cycle_at10", readdataM, 32'd10);
        step(1'b0, 32'd0, 32'd0);
        check("irq_match", {31'd0, irq}, 32'd1);
        peek(32'hFFFF000C);
        check("status_match", readdataM, 32'h0000_0005);
        step(1'b1, 32'hFFFF_000C, 32'h0000_0005);
        check("irq_w1c", {31'd0, irq}, 32'd0);
        step(1'b1, 32'hFFFF_0008, 32'd0);
        step(1'b1, 32'hFFFF_0004, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        check("cmp0_irq", {31'd0, irq}, 32'd0);
        peek(32'hFFFF000C);
        check("cmp0_status", readdataM, 32'h0000_0004);

        // CYCLE clear on write, then wrap from a forced value
        step(1'b1, 32'hFFFF_0004, 32'h0000_1234);
        peek(32'hFFFF0004);
        check("cyc_clear", readdataM, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        peek(32'hFFFF0004);
        check("cyc_after_clear", readdataM, 32'd1);
        force dut.cycle_r = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_r;
        step(1'b0, 32'd0, 32'd0);
        peek(32'hFFFF0004);
        check("cyc_max", readdataM, 32'hFFFF_FFFF);
        step(1'b0, 32'd0, 32'd0);
        peek(32'hFFFF0004);
        check("cyc_wrap", readdataM, 32'd0);

        // LED register, unmapped offset, reset clears LEDs
        step(1'b1, 32'hFFFF_0000, 32'h1234_ABCD);
        check("leds", {16'd0, leds}, 32'h0000_ABCD);
        peek(32'hFFFF0000);
        check("led_readback", readdataM, 32'h0000_ABCD);
        peek(32'hFFFF0010);
        check("unmapped", readdataM, 32'd0);
        rst = 1'b1;
        step(1'b1, 32'h0000_0030, 32'hCAFE_F00D);
        rst = 1'b0;
        check("leds_rst", {16'd0, leds}, 32'd0);
        peek(32'h0000_0030);
        check("ram_in_rst", readdataM, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
